// File: rtl/register_dump_tx_pkg.sv
// Shared types for the register dump transmitter.
// FSM state encoding and byte-count helpers.
package register_dump_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_LOAD     = 3'd2,
    S_SEND     = 3'd3,
    S_WAIT     = 3'd4,
    S_CHK_SEND = 3'd5,
    S_CHK_WAIT = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  function automatic int bytes_per_reg(
    input int nb,
    input int nb_byte
  );
    return nb / nb_byte;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_dump_serializer.sv
// Register-to-byte serializer: shift register, byte counter, last-byte flag.
// Low byte of the shift register is the byte currently on the wire.
module reg_dump_serializer
  import register_dump_tx_pkg::*;
#(
  parameter int NB      = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [NB-1:0]      data,
  output logic [NB_BYTE-1:0] byte_out,
  output logic               last
);

  localparam int BPR = bytes_per_reg(NB, NB_BYTE);
  localparam int CW  = cnt_width(BPR);

  logic [NB-1:0] shreg;
  logic [CW-1:0] cnt;

  // Load a fresh register word or advance one byte per acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= data;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= shreg >> NB_BYTE;
      if (!last) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign byte_out = shreg[NB_BYTE-1:0];
  assign last     = (cnt == CW'(BPR - 1));

endmodule

// File: rtl/register_dump_tx.sv
// Walks the register file debug port and streams every register to the UART.
// Optional trailing XOR checksum byte: define REG_DUMP_CHECKSUM_EN.
module register_dump_tx
  import register_dump_tx_pkg::*;
#(
  parameter int NB       = 32,
  parameter int REGS     = 5,
  parameter int NUM_REGS = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [REGS-1:0]    o_mips_register_number,
  input  logic [NB-1:0]      i_mips_register_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  state_t            state;
  logic [REGS-1:0]   reg_cnt;
  logic              tx_start;
  logic              busy;
  logic              done;
  logic [NB_BYTE-1:0] ser_byte;
  logic              last_byte;
  logic              last_reg;
  logic              ack;
  logic              ser_load;
  logic              ser_shift;

  // A done pulse coinciding with our own start pulse is not an acknowledge
  assign ack       = i_tx_done && !tx_start;
  assign last_reg  = (reg_cnt == REGS'(NUM_REGS - 1));
  assign ser_load  = (state == S_LOAD);
  assign ser_shift = (state == S_WAIT) && ack;

  reg_dump_serializer #(
    .NB      (NB),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .load     (ser_load),
    .shift    (ser_shift),
    .data     (i_mips_register_data),
    .byte_out (ser_byte),
    .last     (last_byte)
  );

`ifdef REG_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] chk;
  logic               chk_phase;

  assign chk_phase = (state == S_CHK_SEND) ||
                     (state == S_CHK_WAIT);
  assign o_tx_data = chk_phase ? chk : ser_byte;
`else
  assign o_tx_data = ser_byte;
`endif

  // Dump sequencer with registered handshake outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= S_IDLE;
      reg_cnt  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      chk      <= '0;
`endif
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            state <= S_ADDR;
            busy  <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            chk   <= '0;
`endif
          end
        end
        S_ADDR: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          state <= S_SEND;
        end
        S_SEND: begin
          tx_start <= 1'b1;
          state    <= S_WAIT;
`ifdef REG_DUMP_CHECKSUM_EN
          chk      <= chk ^ ser_byte;
`endif
        end
        S_WAIT: begin
          if (ack) begin
            if (!last_byte) begin
              state <= S_SEND;
            end else if (!last_reg) begin
              reg_cnt <= reg_cnt + REGS'(1);
              state   <= S_ADDR;
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              state <= S_CHK_SEND;
`else
              state <= S_DONE;
              done  <= 1'b1;
`endif
            end
          end
        end
        S_CHK_SEND: begin
`ifdef REG_DUMP_CHECKSUM_EN
          tx_start <= 1'b1;
          state    <= S_CHK_WAIT;
`else
          state <= S_IDLE;
          busy  <= 1'b0;
`endif
        end
        S_CHK_WAIT: begin
`ifdef REG_DUMP_CHECKSUM_EN
          if (ack) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
`else
          state <= S_IDLE;
          busy  <= 1'b0;
`endif
        end
        S_DONE: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          reg_cnt <= '0;
        end
      endcase
    end
  end

  assign o_mips_register_number = reg_cnt;
  assign o_tx_start             = tx_start;
  assign o_busy                 = busy;
  assign o_done                 = done;

endmodule

// File: tb/tb_register_dump_tx.sv
// Bench for register_dump_tx: regfile and UART TX models, stream scoreboard.
// Honours REG_DUMP_CHECKSUM_EN for the expected stream.
module tb_register_dump_tx;

  localparam int NB       = 32;
  localparam int REGS     = 5;
  localparam int NUM_REGS = 32;
  localparam int NB_BYTE  = 8;
  localparam int BPR      = NB / NB_BYTE;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int NBYTES   = NUM_REGS * BPR + 1;
`else
  localparam int NBYTES   = NUM_REGS * BPR;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            tx_done = 1'b0;
  logic [REGS-1:0] rnum;
  logic [NB-1:0]   rdata;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            busy;
  logic            done;

  logic [NB-1:0]   regfile [NUM_REGS];
  logic [7:0]      got [$];
  logic [7:0]      exp_q [$];

  int checks = 0;
  int errors = 0;
  int tx_delay = 10;
  bit spur = 1'b0;
  int width_err = 0;
  int unstable = 0;
  int done_cnt = 0;

  register_dump_tx #(
    .NB       (NB),
    .REGS     (REGS),
    .NUM_REGS (NUM_REGS),
    .NB_BYTE  (NB_BYTE)
  ) dut (
    .i_clk                  (clk),
    .i_reset                (rst_n),
    .i_start                (start),
    .o_mips_register_number (rnum),
    .i_mips_register_data   (rdata),
    .o_tx_data              (tx_data),
    .o_tx_start             (tx_start),
    .i_tx_done              (tx_done),
    .o_busy                 (busy),
    .o_done                 (done)
  );

  assign rdata = regfile[rnum];

  initial forever #5 clk = ~clk;

  // UART TX model: records bytes, acknowledges tx_delay cycles later
  initial begin
    int pend;
    logic [7:0] held;
    bit prev_start;
    pend = 0;
    held = '0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!rst_n) begin
        pend = 0;
        prev_start = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (tx_start) begin
          if (prev_start) width_err++;
          got.push_back(tx_data);
          held = tx_data;
          pend = tx_delay;
          if (spur) tx_done = 1'b1;
        end else if (pend > 0) begin
          if (tx_data !== held) unstable++;
          pend--;
          if (pend == 0) tx_done = 1'b1;
        end else if (spur && $urandom_range(0, 3) == 0) begin
          tx_done = 1'b1;
        end
        prev_start = tx_start;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Expected stream straight from the byte-order rules
  task automatic build_exp();
    logic [7:0] x;
    exp_q.delete();
    x = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int b = 0; b < BPR; b++) begin
        exp_q.push_back(8'((regfile[r] >> (8 * b)) & 32'hFF));
        x = x ^ 8'((regfile[r] >> (8 * b)) & 32'hFF);
      end
    end
`ifdef REG_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic run_dump(input string tag, input bit measure);
    int first_lat;
    bit ok;
    got.delete();
    done_cnt = 0;
    width_err = 0;
    unstable = 0;
    first_lat = -1;
    ok = 1'b0;
    build_exp();
    if (measure) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int c = 0; c < 8000; c++) begin
      tick();
      if (first_lat < 0 && got.size() > 0) first_lat = c + 1;
      if (done_cnt > 0) begin
        start = 1'b0;
        ok = 1'b1;
        break;
      end
      if (busy) start = spur ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    check({tag, "_timeout"}, 32'(ok), 32'd1);
    for (int c = 0; c < 15; c++) tick();
    if (measure) check({tag, "_latency"}, first_lat, 4);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_nbytes"}, got.size(), NBYTES);
    check({tag, "_start_width"}, width_err, 0);
    check({tag, "_data_stable"}, unstable, 0);
    if (got.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_regnum"}, 32'(rnum), 0);
  endtask

  initial begin
    int sz;
    bit ok;
    for (int n = 0; n < NUM_REGS; n++) regfile[n] = 32'hA500_0000 | n;

    // Reset held with start requested
    start = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check_outputs_zero("reset");
    check("reset_no_tx", got.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_dump("held_start", 1'b0);
    if (got.size() >= 4) begin
      check("first_b3", got[3], 32'hA5);
      check("first_b0", got[0], 32'h00);
    end

    // Latency from an idle start
    run_dump("latency", 1'b1);

    // Random contents with spurious start/done pulses
    for (int n = 0; n < NUM_REGS; n++) regfile[n] = $urandom;
    spur = 1'b1;
    tx_delay = $urandom_range(3, 12);
    run_dump("spurious", 1'b1);
    spur = 1'b0;

    // Random contents, immediate acknowledge
    for (int n = 0; n < NUM_REGS; n++) regfile[n] = $urandom;
    tx_delay = 1;
    run_dump("fast_ack", 1'b1);
    tx_delay = 10;

    // Asynchronous abort after byte 50
    got.delete();
    ok = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (busy) start = 1'b0;
      if (got.size() >= 50) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_reach50", 32'(ok), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("abort");
    for (int c = 0; c < 3; c++) tick();
    sz = got.size();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    check("abort_no_tx", got.size(), sz);
    check("abort_idle", 32'(busy), 0);
    run_dump("restart", 1'b1);

    // Sparse contents: only reg 1 non-zero
    for (int n = 0; n < NUM_REGS; n++) regfile[n] = '0;
    regfile[1] = 32'h0000_00FF;
    run_dump("sparse", 1'b1);
`ifdef REG_DUMP_CHECKSUM_EN
    if (got.size() > 0) check("checksum_ff", got[got.size()-1], 32'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
